// File: rtl/reg_ex_mem_elastic.sv
// EX/MEM pipeline stage with a valid/ready handshake, an optional 1-entry skid buffer,
// synchronous flush, and side-effect controls squashed whenever the MEM side holds a bubble.
module reg_ex_mem_elastic #(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5,
  parameter int RSRC_W  = 2,
  parameter int SKID    = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               valid_e,
  output logic               ready_e,
  input  logic               RegWriteE,
  input  logic               MemWriteE,
  input  logic [RSRC_W-1:0]  ResultSrcE,
  input  logic [XLEN-1:0]    ALUResultE,
  input  logic [XLEN-1:0]    WriteDataE,
  input  logic [XLEN-1:0]    PCPlus4E,
  input  logic [RADDR_W-1:0] RdE,
  output logic               valid_m,
  input  logic               ready_m,
  output logic               RegWriteM,
  output logic               MemWriteM,
  output logic [RSRC_W-1:0]  ResultSrcM,
  output logic [XLEN-1:0]    ALUResultM,
  output logic [XLEN-1:0]    WriteDataM,
  output logic [XLEN-1:0]    PCPlus4M,
  output logic [RADDR_W-1:0] RdM,
  output logic [1:0]         occupancy
);

  localparam int CTL_W  = 2 + RADDR_W;
  localparam int DATA_W = RSRC_W + 3 * XLEN;

  logic              m_valid_q, m_valid_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;
  logic [CTL_W-1:0]  m_ctl_q, m_ctl_d;
  logic              s_valid_q, s_valid_d;
  logic [DATA_W-1:0] s_data_q, s_data_d;
  logic [CTL_W-1:0]  s_ctl_q, s_ctl_d;
  logic [1:0]        occ_q, occ_d;

  logic [DATA_W-1:0] in_data_s;
  logic [CTL_W-1:0]  in_ctl_s;
  logic              ready_e_s;
  logic              take_in_s;

  assign in_data_s = {ResultSrcE, ALUResultE, WriteDataE, PCPlus4E};
  assign in_ctl_s  = {RegWriteE, MemWriteE, RdE};

  // Skid mode: ready depends only on the skid register, never on ready_m.
  assign ready_e_s = (SKID != 0) ? !s_valid_q : (ready_m | !m_valid_q);
  assign take_in_s = valid_e & ready_e_s;

  // Next-state selection for the main and skid entries.
  always_comb begin
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_ctl_d   = m_ctl_q;
    s_valid_d = s_valid_q;
    s_data_d  = s_data_q;
    s_ctl_d   = s_ctl_q;
    if (SKID != 0) begin
      if (!m_valid_q || ready_m) begin
        if (s_valid_q) begin
          m_valid_d = 1'b1;
          m_data_d  = s_data_q;
          m_ctl_d   = s_ctl_q;
          s_valid_d = 1'b0;
        end else if (take_in_s) begin
          m_valid_d = 1'b1;
          m_data_d  = in_data_s;
          m_ctl_d   = in_ctl_s;
        end else begin
          m_valid_d = 1'b0;
          m_ctl_d   = {CTL_W{1'b0}};
        end
      end else if (take_in_s) begin
        s_valid_d = 1'b1;
        s_data_d  = in_data_s;
        s_ctl_d   = in_ctl_s;
      end else begin
        s_valid_d = s_valid_q;
      end
    end else begin
      if (take_in_s) begin
        m_valid_d = 1'b1;
        m_data_d  = in_data_s;
        m_ctl_d   = in_ctl_s;
      end else if (ready_m) begin
        m_valid_d = 1'b0;
        m_ctl_d   = {CTL_W{1'b0}};
      end else begin
        m_valid_d = m_valid_q;
      end
    end
    occ_d = {1'b0, m_valid_d} + {1'b0, s_valid_d};
  end

  // State registers; flush keeps payload but zeroes every side-effect control.
  always_ff @(posedge clk) begin
    if (reset) begin
      m_valid_q <= 1'b0;
      m_data_q  <= {DATA_W{1'b0}};
      m_ctl_q   <= {CTL_W{1'b0}};
      s_valid_q <= 1'b0;
      s_data_q  <= {DATA_W{1'b0}};
      s_ctl_q   <= {CTL_W{1'b0}};
      occ_q     <= 2'd0;
    end else if (flush) begin
      m_valid_q <= 1'b0;
      m_ctl_q   <= {CTL_W{1'b0}};
      s_valid_q <= 1'b0;
      occ_q     <= 2'd0;
    end else begin
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_ctl_q   <= m_ctl_d;
      s_valid_q <= s_valid_d;
      s_data_q  <= s_data_d;
      s_ctl_q   <= s_ctl_d;
      occ_q     <= occ_d;
    end
  end

  assign ready_e    = ready_e_s;
  assign valid_m    = m_valid_q;
  assign RegWriteM  = m_ctl_q[CTL_W-1];
  assign MemWriteM  = m_ctl_q[CTL_W-2];
  assign RdM        = m_ctl_q[RADDR_W-1:0];
  assign ResultSrcM = m_data_q[DATA_W-1 -: RSRC_W];
  assign ALUResultM = m_data_q[3*XLEN-1 -: XLEN];
  assign WriteDataM = m_data_q[2*XLEN-1 -: XLEN];
  assign PCPlus4M   = m_data_q[XLEN-1:0];
  assign occupancy  = occ_q;

endmodule

// File: tb/tb_reg_ex_mem_elastic.sv
// Directed bench: A = SKID 1 / 32-bit (vector table), B = SKID 0, C = SKID 1 / 64-bit, 6-bit Rd.
module tb_reg_ex_mem_elastic;

  logic        clk = 1'b0;
  logic        reset, flush, valid_e;
  logic        rm_a, rm_b, rm_c;
  logic        rw_e, mw_e;
  logic [1:0]  rsrc_e;
  logic [63:0] alu_e, wd_e, pc_e;
  logic [5:0]  rd_e;

  logic        re_a, vm_a, rw_a, mw_a;
  logic [1:0]  rs_a, occ_a;
  logic [31:0] alu_a, wd_a, pc_a;
  logic [4:0]  rd_a;
  logic        re_b, vm_b, rw_b, mw_b;
  logic [1:0]  rs_b, occ_b;
  logic [31:0] alu_b, wd_b, pc_b;
  logic [4:0]  rd_b;
  logic        re_c, vm_c, rw_c, mw_c;
  logic [1:0]  rs_c, occ_c;
  logic [63:0] alu_c, wd_c, pc_c;
  logic [5:0]  rd_c;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reg_ex_mem_elastic #(.XLEN(32), .RADDR_W(5), .RSRC_W(2), .SKID(1)) dut_a (
    .clk(clk), .reset(reset), .flush(flush), .valid_e(valid_e), .ready_e(re_a),
    .RegWriteE(rw_e), .MemWriteE(mw_e), .ResultSrcE(rsrc_e), .ALUResultE(alu_e[31:0]),
    .WriteDataE(wd_e[31:0]), .PCPlus4E(pc_e[31:0]), .RdE(rd_e[4:0]), .valid_m(vm_a),
    .ready_m(rm_a), .RegWriteM(rw_a), .MemWriteM(mw_a), .ResultSrcM(rs_a), .ALUResultM(alu_a),
    .WriteDataM(wd_a), .PCPlus4M(pc_a), .RdM(rd_a), .occupancy(occ_a));

  reg_ex_mem_elastic #(.XLEN(32), .RADDR_W(5), .RSRC_W(2), .SKID(0)) dut_b (
    .clk(clk), .reset(reset), .flush(flush), .valid_e(valid_e), .ready_e(re_b),
    .RegWriteE(rw_e), .MemWriteE(mw_e), .ResultSrcE(rsrc_e), .ALUResultE(alu_e[31:0]),
    .WriteDataE(wd_e[31:0]), .PCPlus4E(pc_e[31:0]), .RdE(rd_e[4:0]), .valid_m(vm_b),
    .ready_m(rm_b), .RegWriteM(rw_b), .MemWriteM(mw_b), .ResultSrcM(rs_b), .ALUResultM(alu_b),
    .WriteDataM(wd_b), .PCPlus4M(pc_b), .RdM(rd_b), .occupancy(occ_b));

  reg_ex_mem_elastic #(.XLEN(64), .RADDR_W(6), .RSRC_W(2), .SKID(1)) dut_c (
    .clk(clk), .reset(reset), .flush(flush), .valid_e(valid_e), .ready_e(re_c),
    .RegWriteE(rw_e), .MemWriteE(mw_e), .ResultSrcE(rsrc_e), .ALUResultE(alu_e),
    .WriteDataE(wd_e), .PCPlus4E(pc_e), .RdE(rd_e), .valid_m(vm_c),
    .ready_m(rm_c), .RegWriteM(rw_c), .MemWriteM(mw_c), .ResultSrcM(rs_c), .ALUResultM(alu_c),
    .WriteDataM(wd_c), .PCPlus4M(pc_c), .RdM(rd_c), .occupancy(occ_c));

  typedef struct {
    logic        ve, rm, fl;
    logic [31:0] alu;
    logic [4:0]  rd;
    logic        rw, mw;
    logic        vm_x;
    logic [31:0] alu_x;
    logic [4:0]  rd_x;
    logic        rw_x, mw_x, re_x;
    logic [1:0]  occ_x;
  } vec_t;

  vec_t tbl[19];

  function automatic vec_t mk(input logic ve, input logic rm, input logic fl,
                              input logic [31:0] alu, input logic [4:0] rd,
                              input logic rw, input logic mw, input logic vm_x,
                              input logic [31:0] alu_x, input logic [4:0] rd_x,
                              input logic rw_x, input logic mw_x, input logic re_x,
                              input logic [1:0] occ_x);
    vec_t v;
    v.ve = ve; v.rm = rm; v.fl = fl; v.alu = alu; v.rd = rd; v.rw = rw; v.mw = mw;
    v.vm_x = vm_x; v.alu_x = alu_x; v.rd_x = rd_x; v.rw_x = rw_x; v.mw_x = mw_x;
    v.re_x = re_x; v.occ_x = occ_x;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ve, input logic [63:0] alu, input logic [5:0] rd,
                       input logic rw, input logic mw);
    valid_e = ve; alu_e = alu; rd_e = rd; rw_e = rw; mw_e = mw;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; valid_e = 1'b0; rm_a = 1'b1; rm_b = 1'b1; rm_c = 1'b1;
    rw_e = 1'b0; mw_e = 1'b0; rsrc_e = 2'b01; alu_e = 64'd0; wd_e = 64'd0; pc_e = 64'd0;
    rd_e = 6'd0;

    tbl[0]  = mk(1, 1, 0, 32'h10, 5'd1, 1, 0,  1, 32'h10, 5'd1, 1, 0, 1, 2'd1);
    tbl[1]  = mk(1, 1, 0, 32'h20, 5'd2, 1, 0,  1, 32'h20, 5'd2, 1, 0, 1, 2'd1);
    tbl[2]  = mk(1, 1, 0, 32'h30, 5'd3, 1, 0,  1, 32'h30, 5'd3, 1, 0, 1, 2'd1);
    tbl[3]  = mk(0, 1, 0, 32'h0,  5'd0, 0, 0,  0, 32'h0,  5'd0, 0, 0, 1, 2'd0);
    tbl[4]  = mk(1, 1, 0, 32'hA0, 5'd4, 1, 1,  1, 32'hA0, 5'd4, 1, 1, 1, 2'd1);
    tbl[5]  = mk(1, 0, 0, 32'hB0, 5'd5, 1, 0,  1, 32'hA0, 5'd4, 1, 1, 0, 2'd2);
    tbl[6]  = mk(1, 0, 0, 32'hC0, 5'd6, 1, 0,  1, 32'hA0, 5'd4, 1, 1, 0, 2'd2);
    tbl[7]  = mk(0, 1, 0, 32'h0,  5'd0, 0, 0,  1, 32'hB0, 5'd5, 1, 0, 1, 2'd1);
    tbl[8]  = mk(0, 1, 0, 32'h0,  5'd0, 0, 0,  0, 32'h0,  5'd0, 0, 0, 1, 2'd0);
    tbl[9]  = mk(1, 1, 0, 32'h11, 5'd7, 1, 1,  1, 32'h11, 5'd7, 1, 1, 1, 2'd1);
    tbl[10] = mk(1, 0, 0, 32'h22, 5'd8, 1, 1,  1, 32'h11, 5'd7, 1, 1, 0, 2'd2);
    tbl[11] = mk(1, 0, 1, 32'h33, 5'd9, 1, 1,  0, 32'h0,  5'd0, 0, 0, 1, 2'd0);
    tbl[12] = mk(0, 1, 0, 32'h0,  5'd0, 0, 0,  0, 32'h0,  5'd0, 0, 0, 1, 2'd0);
    tbl[13] = mk(1, 1, 1, 32'h99, 5'd15, 1, 1, 0, 32'h0,  5'd0, 0, 0, 1, 2'd0);
    tbl[14] = mk(0, 1, 0, 32'h0,  5'd0, 0, 0,  0, 32'h0,  5'd0, 0, 0, 1, 2'd0);
    tbl[15] = mk(1, 1, 0, 32'h44, 5'd10, 1, 1, 1, 32'h44, 5'd10, 1, 1, 1, 2'd1);
    tbl[16] = mk(1, 0, 0, 32'h55, 5'd11, 1, 0, 1, 32'h44, 5'd10, 1, 1, 0, 2'd2);
    tbl[17] = mk(1, 1, 0, 32'h66, 5'd12, 1, 1, 1, 32'h55, 5'd11, 1, 0, 1, 2'd1);
    tbl[18] = mk(0, 1, 0, 32'h0,  5'd0, 0, 0,  0, 32'h0,  5'd0, 0, 0, 1, 2'd0);

    // Reset held for two edges with no input offered.
    tick();
    tick();
    chk("rst_vm_a", {63'd0, vm_a}, 64'd0);
    chk("rst_re_a", {63'd0, re_a}, 64'd1);
    chk("rst_occ_a", {62'd0, occ_a}, 64'd0);
    chk("rst_alu_a", {32'd0, alu_a}, 64'd0);
    chk("rst_rd_a", {59'd0, rd_a}, 64'd0);
    chk("rst_rw_mw_a", {62'd0, rw_a, mw_a}, 64'd0);
    chk("rst_rs_wd_pc_a", {rs_a, wd_a, pc_a}, 64'd0);
    chk("rst_re_b", {63'd0, re_b}, 64'd1);
    chk("rst_vm_b", {63'd0, vm_b}, 64'd0);
    chk("rst_re_c", {63'd0, re_c}, 64'd1);
    chk("rst_alu_c", alu_c, 64'd0);
    reset = 1'b0;

    for (int i = 0; i < 19; i++) begin
      valid_e = tbl[i].ve; rm_a = tbl[i].rm; flush = tbl[i].fl;
      alu_e = {32'd0, tbl[i].alu}; rd_e = {1'b0, tbl[i].rd};
      rw_e = tbl[i].rw; mw_e = tbl[i].mw;
      tick();
      chk($sformatf("v%0d_valid_m", i), {63'd0, vm_a}, {63'd0, tbl[i].vm_x});
      chk($sformatf("v%0d_RdM", i), {59'd0, rd_a}, {59'd0, tbl[i].rd_x});
      chk($sformatf("v%0d_RegWriteM", i), {63'd0, rw_a}, {63'd0, tbl[i].rw_x});
      chk($sformatf("v%0d_MemWriteM", i), {63'd0, mw_a}, {63'd0, tbl[i].mw_x});
      chk($sformatf("v%0d_ready_e", i), {63'd0, re_a}, {63'd0, tbl[i].re_x});
      chk($sformatf("v%0d_occupancy", i), {62'd0, occ_a}, {62'd0, tbl[i].occ_x});
      if (tbl[i].vm_x) chk($sformatf("v%0d_ALUResultM", i), {32'd0, alu_a}, {32'd0, tbl[i].alu_x});
    end
    flush = 1'b0;

    // Reset during a two-entry stall: everything is lost, payload cleared.
    rm_a = 1'b0;
    drive(1'b1, 64'h5A, 6'd3, 1'b1, 1'b1); tick();
    drive(1'b1, 64'h6B, 6'd4, 1'b1, 1'b1); tick();
    chk("stall2_occ", {62'd0, occ_a}, 64'd2);
    reset = 1'b1; drive(1'b0, 64'h0, 6'd0, 1'b0, 1'b0); tick();
    reset = 1'b0;
    chk("rst_stall_vm", {63'd0, vm_a}, 64'd0);
    chk("rst_stall_occ", {62'd0, occ_a}, 64'd0);
    chk("rst_stall_re", {63'd0, re_a}, 64'd1);
    chk("rst_stall_alu", {32'd0, alu_a}, 64'd0);
    chk("rst_stall_rd", {59'd0, rd_a}, 64'd0);

    // Reset and flush together: payload must be cleared, not left stale.
    drive(1'b1, 64'h77, 6'd9, 1'b1, 1'b0); tick();
    reset = 1'b1; flush = 1'b1; drive(1'b1, 64'h78, 6'd8, 1'b1, 1'b1); tick();
    reset = 1'b0; flush = 1'b0;
    chk("rst_flush_vm", {63'd0, vm_a}, 64'd0);
    chk("rst_flush_alu", {32'd0, alu_a}, 64'd0);
    chk("rst_flush_occ", {62'd0, occ_a}, 64'd0);
    rm_a = 1'b1;

    // SKID = 0: combinational ready_e and replace-on-drain.
    drive(1'b1, 64'h77, 6'd12, 1'b1, 1'b1); rm_b = 1'b0; tick();
    chk("s0_load_vm", {63'd0, vm_b}, 64'd1);
    chk("s0_load_alu", {32'd0, alu_b}, 64'h77);
    chk("s0_ready_low", {63'd0, re_b}, 64'd0);
    chk("s0_occ1", {62'd0, occ_b}, 64'd1);
    drive(1'b1, 64'hEE, 6'd14, 1'b0, 1'b0); tick();
    chk("s0_hold_alu", {32'd0, alu_b}, 64'h77);
    chk("s0_hold_rd", {59'd0, rd_b}, 64'd12);
    drive(1'b1, 64'h88, 6'd13, 1'b1, 1'b0); rm_b = 1'b1; #1;
    chk("s0_ready_comb", {63'd0, re_b}, 64'd1);
    chk("s0_pre_edge_alu", {32'd0, alu_b}, 64'h77);
    tick();
    chk("s0_replace_alu", {32'd0, alu_b}, 64'h88);
    chk("s0_replace_rd", {59'd0, rd_b}, 64'd13);
    chk("s0_replace_mw", {63'd0, mw_b}, 64'd0);
    drive(1'b0, 64'h0, 6'd0, 1'b0, 1'b0); tick();
    chk("s0_drain_vm", {63'd0, vm_b}, 64'd0);
    chk("s0_drain_rd", {59'd0, rd_b}, 64'd0);
    chk("s0_drain_rw", {63'd0, rw_b}, 64'd0);
    chk("s0_drain_occ", {62'd0, occ_b}, 64'd0);

    // 64-bit / 6-bit Rd instance: bit-exact copy, one-cycle latency.
    wd_e = 64'h0123_4567_89AB_CDEF; pc_e = 64'h8000_0000_0000_0004; rsrc_e = 2'b10;
    drive(1'b1, 64'hFFFF_0000_DEAD_BEEF, 6'd63, 1'b1, 1'b0); tick();
    chk("w64_vm", {63'd0, vm_c}, 64'd1);
    chk("w64_alu", alu_c, 64'hFFFF_0000_DEAD_BEEF);
    chk("w64_rd", {58'd0, rd_c}, 64'd63);
    chk("w64_wd", wd_c, 64'h0123_4567_89AB_CDEF);
    chk("w64_pc", pc_c, 64'h8000_0000_0000_0004);
    chk("w64_rs", {62'd0, rs_c}, 64'd2);
    drive(1'b0, 64'h0, 6'd0, 1'b0, 1'b0); tick();
    chk("w64_drain_vm", {63'd0, vm_c}, 64'd0);
    chk("w64_drain_rd", {58'd0, rd_c}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_ex_mem_elastic.md
Name: reg_ex_mem_elastic

Overview:
Parametrised EX/MEM pipeline stage for the RISC-V core. It replaces the fixed always-load register with an elastic stage that uses a valid/ready handshake. It adds an optional skid buffer, synchronous flush and bubble squashing of side-effect controls. It sits between the ALU (EX) and the data-memory/hazard logic (MEM).

Parameters:
XLEN, 32, width of ALUResult, WriteData and PCPlus4 fields
RADDR_W, 5, width of the destination register index
RSRC_W, 2, width of ResultSrc
SKID, 1, 1 = registered ready_e with a 1-entry skid buffer; 0 = pass-through ready, no skid

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high reset
flush  in  1  synchronous kill of all held entries (branch mispredict / exception)
valid_e  in  1  EX stage presents an instruction
ready_e  out  1  stage can accept this cycle
RegWriteE  in  1  control
MemWriteE  in  1  control
ResultSrcE  in  RSRC_W  control
ALUResultE  in  XLEN  data
WriteDataE  in  XLEN  data
PCPlus4E  in  XLEN  data
RdE  in  RADDR_W  destination register
valid_m  out  1  MEM-side entry valid
ready_m  in  1  MEM stage accepts this cycle (0 = stall)
RegWriteM  out  1  gated with valid_m
MemWriteM  out  1  gated with valid_m
ResultSrcM  out  RSRC_W  held payload
ALUResultM  out  XLEN  held payload
WriteDataM  out  XLEN  held payload
PCPlus4M  out  XLEN  held payload
RdM  out  RADDR_W  forced 0 when valid_m = 0
occupancy  out  2  entries held (0..2; max 1 when SKID = 0)

Behaviour:
- Transfer in: valid_e & ready_e at a rising edge. Transfer out: valid_m & ready_m at a rising edge.
- Storage: main entry M (drives outputs) and, when SKID = 1, skid entry S. Each entry has a valid bit and a payload.
- Reset: registers are sampled only at the clk edge. All valid bits and payloads are cleared to 0. After reset, every output is 0 except ready_e. ready_e is 1 after reset in both modes, because the stage is empty.
- Flush: clears M.valid and S.valid in the same edge. It has priority over any load or shift in that edge, so the input offered that cycle is discarded. Payload registers may keep stale data.
- Bubble squash: RegWriteM, MemWriteM and RdM are 0 whenever valid_m = 0. A squashed entry must never write the register file or memory.
- Latency: 1 cycle from an accepted input to valid_m when M is empty or draining.
- SKID = 1:
  - ready_e = !S.valid, a registered signal with no combinational path from ready_m.
  - Cases at each edge:
    - M empty, or M draining (ready_m = 1), and S empty: an accepted input loads into M.
    - M full, ready_m = 0, input accepted: the input loads into S.
    - M draining and S full: S moves to M and S empties. ready_e was 0, so there is no input to accept.
    - M draining, S empty, no input: M.valid is cleared.
  - Stage order is preserved; S never overtakes M.
- SKID = 0:
  - ready_e = ready_m | !M.valid, which is combinational.
  - An accepted input loads into M. If M drains with no new input, M.valid is cleared.
- Stall hold: with valid_m = 1 and ready_m = 0, every M output stays bit-stable.
- occupancy = M.valid + S.valid.
- Widths: payload is copied bit-exact with no arithmetic, sign extension or truncation.
- Reset and flush asserted together: behaves as reset.
- Reset during a stall: the stalled entry is lost and the stage is empty on the next cycle.

Test Plan:
- Reset then idle, with reset asserted for 2 edges and valid_e = 0 → all M outputs 0, valid_m = 0, ready_e = 1, occupancy = 0.
- Stream, SKID = 1, ready_m = 1: ALUResultE = 0x10, 0x20, 0x30 on back-to-back cycles with RdE = 1, 2, 3 → ALUResultM = 0x10, 0x20, 0x30 one cycle later each; ready_e stays 1.
- Stall, SKID = 1: accept A (0xA0), then drop ready_m and offer B (0xB0) → B goes to skid, occupancy = 2, ready_e = 0, M holds 0xA0. Raise ready_m → 0xA0 then 0xB0 are delivered in order and ready_e returns to 1.
- Flush mid-stall with occupancy = 2, RegWriteE = MemWriteE = 1 → next cycle valid_m = 0, RegWriteM = MemWriteM = 0, RdM = 0, occupancy = 0. The input offered in the flush cycle is not delivered.
- SKID = 0, ready_m = 0, M full → ready_e = 0 in the same cycle. Raise ready_m with valid_e = 1 → ready_e = 1 combinationally and the new payload replaces M at the edge.
- Parameter sweep XLEN = 64, RADDR_W = 6: ALUResultE = 0xFFFF_0000_DEAD_BEEF, RdE = 63 → delivered unchanged after 1 cycle.
